// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response interface for fetch_stage
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            ImemReqF;
  logic [XLEN-1:0] ImemAddrF;
  logic            ImemReadyF;
  logic [XLEN-1:0] ImemRdataF;

  modport master (
    output ImemReqF,
    output ImemAddrF,
    input  ImemReadyF,
    input  ImemRdataF
  );

  modport slave (
    input  ImemReqF,
    input  ImemAddrF,
    output ImemReadyF,
    output ImemRdataF
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage with req/ready imem fetch, one-entry hold buffer, E-stage redirect (optional FETCH_MISALIGN_TRAP_EN)
module fetch_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  fetch_stage_if.master   imem,
  input  logic            i_StallD,
  input  logic            i_FlushD,
  input  logic            i_NeedBranchE,
  input  logic            i_JumpE,
  input  logic [XLEN-1:0] i_PCTargetE,
  output logic [XLEN-1:0] o_InstrD,
  output logic [XLEN-1:0] o_PCD,
  output logic [XLEN-1:0] o_PCPlus4D,
  output logic            o_ValidD,
  output logic            o_FetchBusyF,
  output logic            o_MisalignErrF
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_hold_buf;
  logic [XLEN-1:0] r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pcplus4_d;
  logic            r_valid_d;
  logic            r_misalign;
  logic            r_halt_pend;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_mis;
  logic            w_req;
  logic            w_fire;
  logic            w_adv;
  logic [XLEN-1:0] w_pcf_plus4;
  logic [XLEN-1:0] w_next_pcf;
  logic [XLEN-1:0] w_next_req_addr;
  logic            w_load;
  logic [XLEN-1:0] w_load_data;
  logic            w_capture;
  logic            w_next_halt_pend;
  logic            w_set_mis;

  assign w_redirect  = i_NeedBranchE | i_JumpE;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_target    = i_PCTargetE;
  assign w_mis       = w_redirect & (|i_PCTargetE[1:0]);
`else
  // Without the trap, low target bits are simply ignored.
  assign w_target    = i_PCTargetE & ~XLEN'(3);
  assign w_mis       = 1'b0;
`endif
  assign w_req       = (r_state == S_REQ) || (r_state == S_DROP);
  assign w_fire      = w_req & imem.ImemReadyF;
  // A flush overrides a stall, so the fetched word is consumed (and bubbled).
  assign w_adv       = !i_StallD || i_FlushD;
  assign w_pcf_plus4 = r_pcf + XLEN'(4);

  assign imem.ImemReqF  = w_req;
  assign imem.ImemAddrF = r_req_addr;
  assign o_InstrD       = r_instr_d;
  assign o_PCD          = r_pc_d;
  assign o_PCPlus4D     = r_pcplus4_d;
  assign o_ValidD       = r_valid_d;
  assign o_MisalignErrF = r_misalign;
  assign o_FetchBusyF   = !((r_state == S_REQ) && w_fire) && !(r_state == S_HOLD);

  // Next-state, next-PC and IF/ID load decision.
  always_comb begin
    w_next_state     = r_state;
    w_next_pcf       = r_pcf;
    w_next_req_addr  = r_req_addr;
    w_load           = 1'b0;
    w_load_data      = imem.ImemRdataF;
    w_capture        = 1'b0;
    w_next_halt_pend = r_halt_pend;
    w_set_mis        = 1'b0;
    case (r_state)
      S_IDLE: w_next_state = S_REQ;
      S_REQ: begin
        if (w_fire && w_redirect) begin
          if (w_mis) begin
            w_set_mis    = 1'b1;
            w_next_state = S_HALT;
          end else begin
            w_next_pcf      = w_target;
            w_next_req_addr = w_target;
          end
        end else if (w_fire && w_adv) begin
          w_load          = 1'b1;
          w_next_pcf      = w_pcf_plus4;
          w_next_req_addr = w_pcf_plus4;
        end else if (w_fire) begin
          w_capture    = 1'b1;
          w_next_state = S_HOLD;
        end else if (w_redirect) begin
          // Request already on the bus must complete; its data is thrown away in DROP.
          w_next_state = S_DROP;
          if (w_mis) begin
            w_set_mis        = 1'b1;
            w_next_halt_pend = 1'b1;
          end else begin
            w_next_pcf = w_target;
          end
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          if (w_mis) begin
            w_set_mis    = 1'b1;
            w_next_state = S_HALT;
          end else begin
            w_next_pcf      = w_target;
            w_next_req_addr = w_target;
            w_next_state    = S_REQ;
          end
        end else if (w_adv) begin
          w_load          = 1'b1;
          w_load_data     = r_hold_buf;
          w_next_pcf      = w_pcf_plus4;
          w_next_req_addr = w_pcf_plus4;
          w_next_state    = S_REQ;
        end
      end
      S_DROP: begin
        if (w_redirect) begin
          if (w_mis) begin
            w_set_mis        = 1'b1;
            w_next_halt_pend = 1'b1;
          end else begin
            w_next_pcf = w_target;
          end
        end
        if (w_fire) begin
          w_next_req_addr = w_next_pcf;
          if (w_next_halt_pend) begin
            w_next_state = S_HALT;
          end else begin
            w_next_state = S_REQ;
          end
        end
      end
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM state, PC, request address, hold buffer and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pcf       <= RESET_VECTOR;
      r_req_addr  <= RESET_VECTOR;
      r_hold_buf  <= '0;
      r_halt_pend <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pcf       <= w_next_pcf;
      r_req_addr  <= w_next_req_addr;
      r_halt_pend <= w_next_halt_pend;
      r_misalign  <= r_misalign | w_set_mis;
      if (w_capture) begin
        r_hold_buf <= imem.ImemRdataF;
      end
    end
  end

  // IF/ID register: bubble on flush/redirect, load on delivery, else hold or bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (w_redirect || i_FlushD) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (w_load) begin
      r_instr_d   <= w_load_data;
      r_pc_d      <= r_pcf;
      r_pcplus4_d <= w_pcf_plus4;
      r_valid_d   <= 1'b1;
    end else if (!i_StallD) begin
      r_instr_d   <= NOP_INSTR;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage (memory returns ~address)
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        StallD, FlushD, NeedBranchE, JumpE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusyF, MisalignErrF;
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_stage_if #(.XLEN(32)) bus ();

  // Memory word at address a is ~a, so word@8 = FFFFFFF7, word@0x40 = FFFFFFBF.
  assign bus.ImemRdataF = ~bus.ImemAddrF;

  fetch_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem           (bus.master),
    .i_StallD       (StallD),
    .i_FlushD       (FlushD),
    .i_NeedBranchE  (NeedBranchE),
    .i_JumpE        (JumpE),
    .i_PCTargetE    (PCTargetE),
    .o_InstrD       (InstrD),
    .o_PCD          (PCD),
    .o_PCPlus4D     (PCPlus4D),
    .o_ValidD       (ValidD),
    .o_FetchBusyF   (FetchBusyF),
    .o_MisalignErrF (MisalignErrF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; StallD = 1'b0; FlushD = 1'b0; NeedBranchE = 1'b0; JumpE = 1'b0;
    PCTargetE = 32'h0; bus.ImemReadyF = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   {31'b0, bus.ImemReqF}, 32'd0);
    chk("rst_addr",  bus.ImemAddrF, 32'h0);
    chk("rst_instr", InstrD, 32'h0000_0013);
    chk("rst_pcd",   PCD, 32'h0);
    chk("rst_pcp4",  PCPlus4D, 32'h0);
    chk("rst_valid", {31'b0, ValidD}, 32'd0);
    chk("rst_busy",  {31'b0, FetchBusyF}, 32'd1);
    chk("rst_mis",   {31'b0, MisalignErrF}, 32'd0);
    reset_n = 1'b1;

    // Streaming fetch
    @(negedge clk);                                   // N1
    chk("n1_req",   {31'b0, bus.ImemReqF}, 32'd1);
    chk("n1_addr",  bus.ImemAddrF, 32'h0);
    chk("n1_valid", {31'b0, ValidD}, 32'd0);
    @(negedge clk);                                   // N2
    chk("n2_addr",  bus.ImemAddrF, 32'h4);
    chk("n2_valid", {31'b0, ValidD}, 32'd1);
    chk("n2_instr", InstrD, 32'hFFFF_FFFF);
    chk("n2_pcd",   PCD, 32'h0);
    chk("n2_pcp4",  PCPlus4D, 32'h4);
    chk("n2_busy",  {31'b0, FetchBusyF}, 32'd0);
    @(negedge clk);                                   // N3
    chk("n3_addr",  bus.ImemAddrF, 32'h8);
    chk("n3_pcd",   PCD, 32'h4);

    // Stall while fetching addr 8: HOLD for three cycles
    StallD = 1'b1;
    @(negedge clk);                                   // N4
    chk("hold_req",  {31'b0, bus.ImemReqF}, 32'd0);
    chk("hold_busy", {31'b0, FetchBusyF}, 32'd0);
    chk("hold_pcd",  PCD, 32'h4);
    @(negedge clk);
    @(negedge clk);                                   // N6
    chk("hold3_req", {31'b0, bus.ImemReqF}, 32'd0);
    StallD = 1'b0;
    @(negedge clk);                                   // N7
    chk("rel_instr", InstrD, 32'hFFFF_FFF7);
    chk("rel_pcd",   PCD, 32'h8);
    chk("rel_addr",  bus.ImemAddrF, 32'hC);
    chk("rel_req",   {31'b0, bus.ImemReqF}, 32'd1);

    // Branch while request at 0x10 waits for ready
    @(negedge clk);                                   // N8
    chk("pre_br_addr", bus.ImemAddrF, 32'h10);
    bus.ImemReadyF = 1'b0; NeedBranchE = 1'b1; PCTargetE = 32'h40;
    @(negedge clk);                                   // N9
    chk("drop_addr",  bus.ImemAddrF, 32'h10);
    chk("drop_req",   {31'b0, bus.ImemReqF}, 32'd1);
    chk("drop_valid", {31'b0, ValidD}, 32'd0);
    NeedBranchE = 1'b0;
    @(negedge clk);                                   // N10
    chk("drop2_addr", bus.ImemAddrF, 32'h10);
    bus.ImemReadyF = 1'b1;
    #1;
    chk("drop_busy",  {31'b0, FetchBusyF}, 32'd1);
    @(negedge clk);                                   // N11
    chk("br_addr",    bus.ImemAddrF, 32'h40);
    chk("br_valid",   {31'b0, ValidD}, 32'd0);
    @(negedge clk);                                   // N12
    chk("br_instr",   InstrD, 32'hFFFF_FFBF);
    chk("br_pcd",     PCD, 32'h40);

    // Jump on the same cycle as a fire
    JumpE = 1'b1; PCTargetE = 32'h100;
    @(negedge clk);                                   // N13
    chk("jmp_valid", {31'b0, ValidD}, 32'd0);
    chk("jmp_instr", InstrD, 32'h0000_0013);
    chk("jmp_addr",  bus.ImemAddrF, 32'h100);
    JumpE = 1'b0;
    @(negedge clk);                                   // N14
    chk("jmp_pcd",   PCD, 32'h100);
    chk("jmp_word",  InstrD, 32'hFFFF_FEFF);

    // Wrap around the top of the address space
    JumpE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    @(negedge clk);                                   // N15
    chk("wrap_addr0", bus.ImemAddrF, 32'hFFFF_FFFC);
    JumpE = 1'b0;
    @(negedge clk);                                   // N16
    chk("wrap_pcd",   PCD, 32'hFFFF_FFFC);
    chk("wrap_pcp4",  PCPlus4D, 32'h0);
    chk("wrap_instr", InstrD, 32'h0000_0003);
    chk("wrap_addr",  bus.ImemAddrF, 32'h0);

    // Flush together with a fire: bubble, but PC still advances
    FlushD = 1'b1; StallD = 1'b1;
    @(negedge clk);                                   // N17
    chk("fl_valid", {31'b0, ValidD}, 32'd0);
    chk("fl_addr",  bus.ImemAddrF, 32'h4);
    FlushD = 1'b0; StallD = 1'b0;
    @(negedge clk);                                   // N18
    chk("fl_pcd",   PCD, 32'h4);

    // Misaligned redirect target
    JumpE = 1'b1; PCTargetE = 32'h42;
    @(negedge clk);                                   // N19
    JumpE = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", {31'b0, MisalignErrF}, 32'd1);
    chk("mis_req",  {31'b0, bus.ImemReqF}, 32'd0);
    chk("mis_busy", {31'b0, FetchBusyF}, 32'd1);
    repeat (3) @(negedge clk);
    chk("mis_req2", {31'b0, bus.ImemReqF}, 32'd0);
    chk("mis_vld",  {31'b0, ValidD}, 32'd0);
    chk("mis_flg2", {31'b0, MisalignErrF}, 32'd1);
`else
    chk("mis_flag", {31'b0, MisalignErrF}, 32'd0);
    chk("mis_addr", bus.ImemAddrF, 32'h40);
    chk("mis_req",  {31'b0, bus.ImemReqF}, 32'd1);
    @(negedge clk);
    chk("mis_pcd",  PCD, 32'h40);
    chk("mis_word", InstrD, 32'hFFFF_FFBF);
`endif

    // Asynchronous reset in the middle of activity
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_req",   {31'b0, bus.ImemReqF}, 32'd0);
    chk("ar_addr",  bus.ImemAddrF, 32'h0);
    chk("ar_valid", {31'b0, ValidD}, 32'd0);
    chk("ar_mis",   {31'b0, MisalignErrF}, 32'd0);
    chk("ar_busy",  {31'b0, FetchBusyF}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ar_restart", bus.ImemAddrF, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
